sram_controller: RTL and testbench

Memory-stage responder that turns the pipeline's 32-bit word load/store requests into two 16-bit accesses on the external SRAM. While an access is in progress it holds `ready` low. The top level drives the pipeline's SRAM stall input from `~ready`, which freezes the fetch PC and the pipeline registers. Data memory is word-addressed above a fixed base. The controller is the only master of the SRAM pins.

---
 rtl/sram_controller_pkg.sv | 24 ++
 rtl/sram_controller.sv | 129 ++++++++++++
 tb/tb_sram_controller.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_pkg.sv
// Shared definitions for the pipeline-to-SRAM memory controller:
// FSM encoding, default data-memory base and external bus widths.
package sram_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_DONE = 2'd3
   } sram_state_t;

   localparam int unsigned SRAM_BASE_ADDR_DEFAULT = 1024;
   localparam int unsigned SRAM_DATA_W            = 16;
   localparam int unsigned SRAM_ADDR_W            = 18;
   localparam int unsigned SRAM_WORD_W            = SRAM_ADDR_W - 1;

   // Word index of a byte address above the data-memory base; the two
   // byte-offset bits fall away in the shift and bits above 18 in the cast.
   function automatic logic [SRAM_WORD_W-1:0] sram_word(input logic [31:0] address,
                                                        input logic [31:0] base);
      return SRAM_WORD_W'((address - base) >> 2);
   endfunction

endpackage

// File: rtl/sram_controller.sv
// Memory-stage responder: splits each 32-bit load/store into a low and a high
// 16-bit SRAM access, holding ready low until the word is complete.
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter int unsigned BASE_ADDR   = SRAM_BASE_ADDR_DEFAULT,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic                   rd_en,
   input  logic [31:0]            address,
   input  logic [31:0]            write_data,
   output logic [31:0]            read_data,
   output logic                   ready,
   inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
   output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
   output logic                   SRAM_WE_N,
   output logic                   SRAM_UB_N,
   output logic                   SRAM_LB_N,
   output logic                   SRAM_CE_N,
   output logic                   SRAM_OE_N
);

   localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   sram_state_t            state, state_nxt;
   logic [CNT_W-1:0]       cnt, cnt_nxt;
   logic                   op_write, op_write_nxt;
   logic                   phase_last;
   logic [SRAM_WORD_W-1:0] word;
   logic                   dq_drive;
   logic [SRAM_DATA_W-1:0] dq_out;

   assign phase_last = (cnt == CNT_LAST);
   assign word       = sram_word(address, BASE_ADDR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         op_write <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         op_write <= op_write_nxt;
      end
   end

   // Handshake: a request (wr_en/rd_en) is held until ready is high; ready is
   // high when idle with nothing requested, or in the single DONE cycle that
   // completes the access. Requests are only looked at in IDLE.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      op_write_nxt = op_write;
      ready        = 1'b0;
      SRAM_ADDR    = '0;
      SRAM_WE_N    = 1'b1;
      dq_drive     = 1'b0;
      dq_out       = '0;

      case (state)
         ST_IDLE: begin
            ready   = ~(wr_en | rd_en);
            cnt_nxt = '0;
            if (wr_en | rd_en) begin
               state_nxt    = ST_LOW;
               op_write_nxt = wr_en;
            end
         end
         ST_LOW: begin
            SRAM_ADDR = {word, 1'b0};
            SRAM_WE_N = ~op_write;
            dq_drive  = op_write;
            dq_out    = write_data[15:0];
            if (phase_last) begin
               state_nxt = ST_HIGH;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_HIGH: begin
            SRAM_ADDR = {word, 1'b1};
            SRAM_WE_N = ~op_write;
            dq_drive  = op_write;
            dq_out    = write_data[31:16];
            if (phase_last) begin
               state_nxt = ST_DONE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_DONE: begin
            ready     = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Load halves are captured on the edge that closes their phase, so the
   // SRAM has had the full wait window to settle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         read_data <= '0;
      end else if (!op_write && phase_last) begin
         if (state == ST_LOW) begin
            read_data[15:0] <= SRAM_DQ;
         end else if (state == ST_HIGH) begin
            read_data[31:16] <= SRAM_DQ;
         end
      end
   end

   assign SRAM_DQ   = dq_drive ? dq_out : {SRAM_DATA_W{1'bz}};
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (WAIT_CYCLES 1 and 3), each on its
// own behavioural 256Kx16 SRAM, checked against a word-level memory model.
module tb_sram_controller;
   import sram_controller_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- stimulus signals ----------------
   logic        wr_en, rd_en, sel, model_oe;
   logic [31:0] address, write_data;

   logic        wr_en1, rd_en1, wr_en3, rd_en3;
   assign wr_en1 = wr_en & ~sel;
   assign rd_en1 = rd_en & ~sel;
   assign wr_en3 = wr_en & sel;
   assign rd_en3 = rd_en & sel;

   logic [31:0] read_data1, read_data3;
   logic        ready1, ready3;
   wire  [15:0] dq1, dq3;
   logic [17:0] addr1, addr3;
   logic        we_n1, we_n3;
   logic        ub1, lb1, ce1, oe1, ub3, lb3, ce3, oe3;

   sram_controller #(.WAIT_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1),
      .address(address), .write_data(write_data),
      .read_data(read_data1), .ready(ready1), .SRAM_DQ(dq1),
      .SRAM_ADDR(addr1), .SRAM_WE_N(we_n1), .SRAM_UB_N(ub1),
      .SRAM_LB_N(lb1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1)
   );

   sram_controller #(.WAIT_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .wr_en(wr_en3), .rd_en(rd_en3),
      .address(address), .write_data(write_data),
      .read_data(read_data3), .ready(ready3), .SRAM_DQ(dq3),
      .SRAM_ADDR(addr3), .SRAM_WE_N(we_n3), .SRAM_UB_N(ub3),
      .SRAM_LB_N(lb3), .SRAM_CE_N(ce3), .SRAM_OE_N(oe3)
   );

   // ---------------- behavioural SRAMs ----------------
   logic [15:0] mem1 [0:262143];
   logic [15:0] mem3 [0:262143];

   assign dq1 = (model_oe && !sel && we_n1) ? mem1[addr1] : 16'bz;
   assign dq3 = (model_oe &&  sel && we_n3) ? mem3[addr3] : 16'bz;

   always @(posedge clk) if (we_n1 === 1'b0) mem1[addr1] <= dq1;
   always @(posedge clk) if (we_n3 === 1'b0) mem3[addr3] <= dq3;

   // ---------------- observation mux ----------------
   logic        o_ready, o_we_n, o_drv;
   logic [17:0] o_addr;
   logic [31:0] o_rdata;
   logic [15:0] o_dq;
   always_comb begin
      o_ready = sel ? ready3     : ready1;
      o_we_n  = sel ? we_n3      : we_n1;
      o_addr  = sel ? addr3      : addr1;
      o_rdata = sel ? read_data3 : read_data1;
      o_drv   = sel ? dut3.dq_drive : dut1.dq_drive;
      o_dq    = sel ? dq3        : dq1;
   end

   // ---------------- scoreboard / model ----------------
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] ref_mem [int];
   logic [31:0] last_rd [2];
   logic [31:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Called just after a rising edge; returns just after the edge that
   // leaves DONE, with the request withdrawn.
   task automatic access(input bit s, input bit w, input bit r,
                         input logic [31:0] addr, input logic [31:0] data);
      int          wc, lows, key;
      bit          done, is_wr;
      logic [16:0] wd;
      logic [17:0] exp_a;
      logic [31:0] got;
      wc    = s ? 3 : 1;
      is_wr = w;
      wd    = 17'((addr - 32'd1024) >> 2);
      key   = int'({s, wd});
      if (!is_wr) exp_q.push_back(ref_mem.exists(key) ? ref_mem[key] : 32'h0);
      sel        = s;
      address    = addr;
      write_data = data;
      model_oe   = !is_wr;
      wr_en      = w;
      rd_en      = r;
      lows = 0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (o_ready === 1'b1) begin
            done = 1'b1;
         end else begin
            if (lows == 0)       exp_a = '0;
            else if (lows <= wc) exp_a = {wd, 1'b0};
            else                 exp_a = {wd, 1'b1};
            chk("sram_addr", 32'(o_addr), 32'(exp_a));
            chk("we_n", 32'(o_we_n), (lows > 0 && is_wr) ? 32'd0 : 32'd1);
            chk("dq_drive", 32'(o_drv), (lows > 0 && is_wr) ? 32'd1 : 32'd0);
            if (is_wr && lows > 0)
               chk("dq_data", 32'(o_dq), (lows <= wc) ? 32'(data[15:0]) : 32'(data[31:16]));
            lows++;
         end
      end
      chk("stall_len", lows, 1 + 2 * wc);
      if (is_wr) begin
         ref_mem[key] = data;
         chk("rd_hold", o_rdata, last_rd[s]);
      end else begin
         got = exp_q.pop_front();
         chk("load_data", o_rdata, got);
         last_rd[s] = got;
      end
      chk("done_we_n", 32'(o_we_n), 32'd1);
      @(posedge clk);
      #1;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      model_oe = 1'b0;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [31:0] d;
      int          key;
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; sel = 1'b0; model_oe = 1'b0;
      address = 32'd1024; write_data = '0;
      last_rd[0] = '0; last_rd[1] = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // idle after reset
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_ready1", 32'(ready1), 32'd1);
         chk("idle_ready3", 32'(ready3), 32'd1);
         chk("idle_we_n", 32'(we_n1), 32'd1);
         chk("idle_drv", 32'(dut1.dq_drive), 32'd0);
         chk("idle_addr", 32'(addr1), 32'd0);
      end
      chk("rst_rdata1", read_data1, 32'd0);
      chk("rst_rdata3", read_data3, 32'd0);
      chk("tie_offs", {28'd0, ub1, lb1, ce1, oe1}, 32'd0);
      @(posedge clk); #1;

      // single store, then inspect the SRAM halves
      access(0, 1, 0, 32'h400, 32'hDEADBEEF);
      chk("mem_lo", 32'(mem1[0]), 32'h0000BEEF);
      chk("mem_hi", 32'(mem1[1]), 32'h0000DEAD);

      // store/load at 0x40C (halves 6 and 7)
      access(0, 1, 0, 32'h40C, 32'h12345678);
      chk("mem6", 32'(mem1[6]), 32'h00005678);
      chk("mem7", 32'(mem1[7]), 32'h00001234);
      access(0, 0, 1, 32'h40C, 32'h0);

      // back-to-back store then load, no gap
      d = $urandom;
      access(0, 1, 0, 32'h404, d);
      access(0, 0, 1, 32'h400, 32'h0);
      chk("mem2", 32'(mem1[2]), 32'(d[15:0]));
      chk("mem3", 32'(mem1[3]), 32'(d[31:16]));

      // three-cycle wait phases
      access(1, 1, 0, 32'h408, $urandom);
      access(1, 0, 1, 32'h408, 32'h0);

      // preload all 16 words on both instances
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 16; i++)
            access(s[0], 1, 0, 32'd1024 + 32'(4 * i), $urandom);

      // random mix; op 2 sets both enables (write wins)
      for (int i = 0; i < 40; i++) begin
         int op;
         op = $urandom_range(0, 2);
         access(1'($urandom_range(0, 1)), op != 0, op != 1,
                32'd1024 + 32'(4 * $urandom_range(0, 15)), $urandom);
      end

      // reset during the HIGH phase of a write
      sel = 1'b0; address = 32'h410; write_data = $urandom; wr_en = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_state", {30'd0, dut1.state}, {30'd0, ST_HIGH});
      rst = 1'b1;
      #1;
      chk("rst_state", {30'd0, dut1.state}, {30'd0, ST_IDLE});
      chk("rst_we_n", 32'(we_n1), 32'd1);
      chk("rst_drv", 32'(dut1.dq_drive), 32'd0);
      chk("rst_rdata", read_data1, 32'd0);
      wr_en = 1'b0;
      last_rd[0] = '0; last_rd[1] = '0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", 32'(ready1), 32'd1);
      key = int'({1'b0, 17'd4});
      ref_mem[key] = {mem1[9], mem1[8]};
      @(posedge clk); #1;
      access(0, 0, 1, 32'h410, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
